serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 164 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - two-requester bit-serial adder controller driving an external 2-cycle registered full adder
// Define SERIAL_ADD_OVF_EN to add the rsp_ovf signed-overflow output.

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             rsp_ovf
`endif
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d, id_q, id_d, rr_q, rr_d;
   logic             fa_a_q, fa_a_d, fa_b_q, fa_b_d, fa_cin_q, fa_cin_d;
   logic             rsp_valid_q, rsp_valid_d, busy_q, busy_d;
   logic             gnt0, gnt1, last_bit;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      id_d     = id_q;
      rr_d     = rr_q;
      fa_a_d   = 1'b0;
      fa_b_d   = 1'b0;
      fa_cin_d = 1'b0;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      last_bit = (idx_q == IW'(WIDTH - 1));
`ifdef SERIAL_ADD_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            // rr_q set means req1 currently holds priority
            gnt0 = req0_valid && (!req1_valid || !rr_q);
            gnt1 = req1_valid && !gnt0;
            if (gnt0 || gnt1) begin
               state_d  = ISSUE;
               id_d     = gnt1;
               rr_d     = gnt0;
               a_d      = gnt1 ? req1_a : req0_a;
               b_d      = gnt1 ? req1_b : req0_b;
               carry_d  = gnt1 ? req1_cin : req0_cin;
               idx_d    = '0;
               fa_a_d   = a_d[0];
               fa_b_d   = b_d[0];
               fa_cin_d = carry_d;
            end
         end
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = CAPTURE;
         CAPTURE: begin
            sum_d[idx_q] = fa_sum;
            carry_d      = fa_cout;
            idx_d        = idx_q + IW'(1);
            if (last_bit) begin
               state_d = RESP;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = carry_q ^ fa_cout;
`endif
            end else begin
               state_d  = ISSUE;
               fa_a_d   = a_q[idx_d];
               fa_b_d   = b_q[idx_d];
               fa_cin_d = fa_cout;
            end
         end
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d      = (state_d != IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         id_q        <= 1'b0;
         rr_q        <= 1'b0;
         fa_a_q      <= 1'b0;
         fa_b_q      <= 1'b0;
         fa_cin_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         id_q        <= id_d;
         rr_q        <= rr_d;
         fa_a_q      <= fa_a_d;
         fa_b_q      <= fa_b_d;
         fa_cin_q    <= fa_cin_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign fa_a       = fa_a_q;
   assign fa_b       = fa_b_q;
   assign fa_cin     = fa_cin_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_sum    = sum_q;
   assign rsp_cout   = carry_q;
   assign busy       = busy_q;
`ifdef SERIAL_ADD_OVF_EN
   assign rsp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with a 2-cycle registered full-adder model

module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid, req0_cin, req1_cin;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [W-1:0] rsp_sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         rsp_ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         id;
      logic [W-1:0] sum;
      bit         cout;
      bit         ovf;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
      , .rsp_ovf(rsp_ovf)
`endif
   );

   // External full adder: two register stages between inputs and outputs
   logic s1_sum, s1_cout;
   always @(posedge clk) begin
      s1_sum  <= fa_a ^ fa_b ^ fa_cin;
      s1_cout <= (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
      fa_sum  <= s1_sum;
      fa_cout <= s1_cout;
   end

   function automatic exp_t model(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin);
      exp_t e;
      logic [W:0] t;
      t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.id   = id;
      e.sum  = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   // Presents a request from a negedge; returns at the negedge following the accept edge.
   task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit cin, output bit ok);
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if ((id && req1_ready) || (!id && req0_ready)) begin
            ok = 1;
            sb.push_back(model(id, a, b, cin));
         end
         @(negedge clk);
         if (ok) break;
      end
      if (id) req1_valid = 0; else req0_valid = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL send_grant: req%0d ready=0 required=1", id); end
   endtask

   // lat counts cycles after the accept edge; called in cycle 1
   task automatic wait_rsp(output bit got, output int lat);
      got = 0; lat = 0;
      for (int i = 1; i <= 200; i++) begin
         if (rsp_valid) begin got = 1; lat = i; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req0_cin = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, rsp_valid, rsp_id, rsp_cout, fa_a, fa_b, fa_cin} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b required 0000000", {busy, rsp_valid, rsp_id, rsp_cout, fa_a, fa_b, fa_cin});
      end
      checks++;
      if (rsp_sum !== '0) begin errors++; $display("FAIL reset_sum: got %h required 00", rsp_sum); end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", rsp_ovf); end
`endif
      reset = 0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: busy=%b ready=%b%b required 0 00", busy, req1_ready, req0_ready);
      end
   endtask

   task automatic test_basic;
      bit ok, got; int lat; exp_t e;
      rsp_ready = 1;
      send(0, 8'h35, 8'h4A, 0, ok);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy); end
      wait_rsp(got, lat);
      checks++;
      if (!got || lat != 3*W+1) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, 3*W+1); end
      e = sb.pop_front();
      checks++;
      if (rsp_sum !== 8'h7F || rsp_sum !== e.sum) begin errors++; $display("FAIL basic_sum: got %h required 7f", rsp_sum); end
      checks++;
      if (rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
         errors++; $display("FAIL basic_cout_id: got %b/%b required 0/0", rsp_cout, rsp_id);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_release: rsp_valid=%b busy=%b required 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_vectors;
      logic [W-1:0] va [6] = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'hAA, 8'hC8};
      logic [W-1:0] vb [6] = '{8'h01, 8'h01, 8'h80, 8'h00, 8'h55, 8'h9C};
      bit           vc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      bit ok, got; int lat; exp_t e;
      rsp_ready = 1;
      for (int k = 0; k < 6; k++) begin
         send(k[0], va[k], vb[k], vc[k], ok);
         wait_rsp(got, lat);
         e = sb.pop_front();
         checks++;
         if (!got || rsp_sum !== e.sum || rsp_cout !== e.cout || rsp_id !== e.id) begin
            errors++;
            $display("FAIL vec%0d: got id=%b sum=%h cout=%b required id=%b sum=%h cout=%b",
                     k, rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
         end
`ifdef SERIAL_ADD_OVF_EN
         checks++;
         if (rsp_ovf !== e.ovf) begin errors++; $display("FAIL vec%0d_ovf: got %b required %b", k, rsp_ovf, e.ovf); end
`endif
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin;
      bit exp_gnt, g, gid; int ngnt, nrsp; exp_t e;
      reset = 1; @(negedge clk); reset = 0;
      sb.delete();
      rsp_ready = 1; exp_gnt = 0; ngnt = 0; nrsp = 0;
      req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      req0_valid = 1; req1_valid = 1;
      for (int cyc = 0; cyc < 400 && nrsp < 4; cyc++) begin
         #1;
         g = 0; gid = 0;
         if (req0_ready && req1_ready) begin errors++; checks++; $display("FAIL rr_double_grant: got 11 required one-hot"); end
         if ((req0_ready || req1_ready) && ngnt < 4) begin
            checks++;
            if (req1_ready !== exp_gnt) begin
               errors++; $display("FAIL rr_order%0d: got req%0d required req%0d", ngnt, req1_ready, exp_gnt);
            end
            gid = req1_ready;
            sb.push_back(gid ? model(1, req1_a, req1_b, req1_cin) : model(0, req0_a, req0_b, req0_cin));
            exp_gnt = ~gid; ngnt++; g = 1;
         end
         if (rsp_valid) begin
            e = sb.pop_front();
            checks++;
            if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_cout !== e.cout) begin
               errors++;
               $display("FAIL rr_rsp%0d: got id=%b sum=%h cout=%b required id=%b sum=%h cout=%b",
                        nrsp, rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
            end
            nrsp++;
         end
         @(negedge clk);
         if (g && gid)  begin req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); end
         if (g && !gid) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); end
         if (ngnt == 4) begin req0_valid = 0; req1_valid = 0; end
      end
      req0_valid = 0; req1_valid = 0;
      checks++;
      if (nrsp != 4) begin errors++; $display("FAIL rr_count: got %0d responses required 4", nrsp); end
   endtask

   task automatic test_backpressure;
      bit ok, got, bad; int lat; exp_t e; logic [W-1:0] s; bit c, id;
      rsp_ready = 0;
      send(0, 8'hA5, 8'h3C, 1, ok);
      wait_rsp(got, lat);
      e = sb.pop_front();
      s = rsp_sum; c = rsp_cout; id = rsp_id;
      checks++;
      if (!got || s !== e.sum || c !== e.cout || id !== e.id) begin
         errors++; $display("FAIL bp_rsp: got sum=%h cout=%b id=%b required sum=%h cout=%b id=%b", s, c, id, e.sum, e.cout, e.id);
      end
      req1_valid = 1; req1_a = 8'h12; req1_b = 8'hF4; req1_cin = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (!rsp_valid || rsp_sum !== s || rsp_cout !== c || rsp_id !== id || req0_ready || req1_ready) bad = 1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL bp_hold: response changed or ready asserted while stalled"); end
      rsp_ready = 1;
      #1;
      checks++;
      if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_ready: got %b required 0", req1_ready); end
      @(negedge clk); #1;
      checks++;
      if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_regrant: ready=%b rsp_valid=%b required 1 0", req1_ready, rsp_valid);
      end
      if (req1_ready) sb.push_back(model(1, req1_a, req1_b, req1_cin));
      @(negedge clk);
      req1_valid = 0;
      wait_rsp(got, lat);
      if (sb.size() != 0) e = sb.pop_front();
      checks++;
      if (!got || lat != 3*W+1 || rsp_sum !== e.sum || rsp_id !== 1'b1) begin
         errors++; $display("FAIL bp_next: got lat=%0d sum=%h id=%b required lat=%0d sum=%h id=1", lat, rsp_sum, rsp_id, 3*W+1, e.sum);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      bit ok, got, seen; int lat; exp_t e;
      rsp_ready = 1;
      send(0, 8'hC3, 8'h5A, 0, ok);
      repeat (9) @(negedge clk);
      #2 reset = 1;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || fa_a !== 1'b0 || fa_cin !== 1'b0) begin
         errors++; $display("FAIL abort_immediate: busy=%b rsp_valid=%b fa_a=%b fa_cin=%b required 0 0 0 0", busy, rsp_valid, fa_a, fa_cin);
      end
      sb.delete();
      @(negedge clk);
      reset = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_no_rsp: got activity after abort required none"); end
      send(1, 8'h80, 8'h80, 1, ok);
      wait_rsp(got, lat);
      e = sb.pop_front();
      checks++;
      if (!got || lat != 3*W+1 || rsp_sum !== e.sum || rsp_cout !== e.cout || rsp_id !== 1'b1) begin
         errors++; $display("FAIL abort_next: got lat=%0d sum=%h cout=%b id=%b required lat=%0d sum=%h cout=%b id=1",
                            lat, rsp_sum, rsp_cout, rsp_id, 3*W+1, e.sum, e.cout);
      end
      @(negedge clk);
   endtask

   task automatic test_drop;
      bit ok, got, seen; int lat; exp_t e;
      rsp_ready = 1;
      send(0, 8'h0F, 8'h11, 0, ok);
      repeat (4) @(negedge clk);
      req1_valid = 1; req1_a = 8'h77; req1_b = 8'h88; req1_cin = 1;
      repeat (3) @(negedge clk);
      req1_valid = 0;
      wait_rsp(got, lat);
      e = sb.pop_front();
      checks++;
      if (!got || rsp_sum !== e.sum || rsp_id !== 1'b0) begin
         errors++; $display("FAIL drop_rsp: got sum=%h id=%b required sum=%h id=0", rsp_sum, rsp_id, e.sum);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid || busy) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL drop_phantom: got activity for dropped request required none"); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_round_robin();
      test_backpressure();
      test_reset_abort();
      test_drop();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
